// File: rtl/ula_pkg.sv
// Shared constants, state type and helpers for the 4-bit ALU arithmetic unit.
package ula_pkg;

    localparam int OP_W     = 4;
    localparam int PROD_W   = 8;
    localparam int MUL_ITER = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement magnitude; -8 maps to 4'b1000, read as unsigned 8.
    function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
        logic [OP_W-1:0] r;
        r = v[OP_W-1] ? (~v + {{(OP_W-1){1'b0}}, 1'b1}) : v;
        return r;
    endfunction

endpackage

// File: rtl/somador_subtrator_4bits.sv
// 4-bit adder/subtractor: sub = 0 gives a + b, sub = 1 gives a - b; carry is the 5th sum bit.
module somador_subtrator_4bits
    import ula_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            sub,
    output logic [OP_W-1:0] soma,
    output logic            carry
);

    logic [OP_W-1:0] b_eff;

    assign b_eff = b ^ {OP_W{sub}};
    assign {carry, soma} = {1'b0, a} + {1'b0, b_eff} + {{OP_W{1'b0}}, sub};

endmodule

// File: rtl/multiplicador_4bits.sv
// Sequential 4-bit shift-and-add multiplier: four iterations per product, one-cycle done pulse.
// Optional signed operation selected by defining MULT_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one add/shift iteration per clock, four in total
// DONE  | produto just written; start here chains the next operation
module multiplicador_4bits
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   multiplicando,
    input  logic [OP_W-1:0]   multiplicador,
    output logic [PROD_W-1:0] produto,
    output logic              busy,
    output logic              done
);

    state_t state, state_next;

    logic [PROD_W-1:0] p_reg;
    logic [PROD_W-1:0] p_next;
    logic [PROD_W-1:0] result;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [OP_W-1:0]   soma;
    logic              carry;
    logic [1:0]        cnt;
    logic              accept;
    logic              last_iter;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == CALC) && (cnt == 2'(MUL_ITER - 1));

    somador_subtrator_4bits u_somador (
        .a     (p_reg[PROD_W-1:OP_W]),
        .b     (a_reg),
        .sub   (1'b0),
        .soma  (soma),
        .carry (carry)
    );

    assign p_next = p_reg[0] ? {carry, soma, p_reg[OP_W-1:1]}
                             : {1'b0, p_reg[PROD_W-1:1]};

`ifdef MULT_SIGNED_EN
    logic neg_reg;

    assign op_a   = magnitude(multiplicando);
    assign op_b   = magnitude(multiplicador);
    assign result = neg_reg ? (~p_next + {{(PROD_W-1){1'b0}}, 1'b1}) : p_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            neg_reg <= 1'b0;
        else if (accept)
            neg_reg <= multiplicando[OP_W-1] ^ multiplicador[OP_W-1];
    end
`else
    assign op_a   = multiplicando;
    assign op_b   = multiplicador;
    assign result = p_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg   <= '0;
            a_reg   <= '0;
            cnt     <= '0;
            produto <= '0;
        end else if (accept) begin
            a_reg <= op_a;
            p_reg <= {{OP_W{1'b0}}, op_b};
            cnt   <= '0;
        end else if (state == CALC) begin
            p_reg <= p_next;
            cnt   <= cnt + 2'd1;
            if (last_iter)
                produto <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_multiplicador_4bits.sv
// Self-checking bench for multiplicador_4bits: directed cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_multiplicador_4bits;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] multiplicando = 4'd0;
    logic [3:0] multiplicador = 4'd0;
    logic [7:0] produto;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] last_prod = 8'h00;

    always #5 clk = ~clk;

    multiplicador_4bits dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .produto       (produto),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [7:0] ref_product(input logic [3:0] a, input logic [3:0] b);
        int x;
        int y;
        x = int'(a);
        y = int'(b);
`ifdef MULT_SIGNED_EN
        if (a[3]) x = x - 16;
        if (b[3]) y = y - 16;
`endif
        return 8'(x * y);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Entered just after a negedge. noise holds start high with junk operands during CALC;
    // chain leaves the bench in the DONE cycle so the next op is accepted back-to-back.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input bit noise, input bit chain);
        logic [7:0] exp;
        exp = ref_product(a, b);
        start = 1'b1;
        multiplicando = a;
        multiplicador = b;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = noise;
            multiplicando = 4'($urandom);
            multiplicador = 4'($urandom);
            chk("busy_calc", 8'(busy), 8'd1);
            chk("done_calc", 8'(done), 8'd0);
            chk("prod_hold", produto, last_prod);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 8'(done), 8'd1);
        chk("busy_end", 8'(busy), 8'd0);
        chk("produto", produto, exp);
        last_prod = exp;
        if (!chain) begin
            @(negedge clk);
            chk("done_fall", 8'(done), 8'd0);
            chk("busy_idle", 8'(busy), 8'd0);
            chk("prod_keep", produto, last_prod);
        end
    endtask

    initial begin
        #12;
        chk("rst_prod", produto, 8'h00);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        op(4'd13, 4'd11, 1'b0, 1'b0);
        op(4'd15, 4'd15, 1'b0, 1'b0);
        op(4'd0,  4'd9,  1'b0, 1'b0);
        op(4'd6,  4'd7,  1'b1, 1'b0);
        op(4'd3,  4'd5,  1'b0, 1'b1);
        op(4'd9,  4'd9,  1'b0, 1'b0);

        // reset asserted during the second iteration of 12 x 12
        start = 1'b1;
        multiplicando = 4'd12;
        multiplicador = 4'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_prod", produto, 8'h00);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_done", 8'(done), 8'd0);
        last_prod = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_busy", 8'(busy), 8'd0);
        op(4'd2, 4'd3, 1'b0, 1'b0);

`ifdef MULT_SIGNED_EN
        op(4'hD, 4'd5, 1'b0, 1'b0);
        op(4'h8, 4'h8, 1'b0, 1'b0);
        op(4'd7, 4'h8, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 40; k++) begin
            op(4'($urandom), 4'($urandom), bit'($urandom_range(0, 1)),
               (k == 39) ? 1'b0 : bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiplicador_4bits.md
# multiplicador_4bits

Sequential 4-bit shift-and-add multiplier, the multiplication counterpart of the restoring divider in the arithmetic unit of the 4-bit ALU. It captures two operands on `start`, runs one add/shift iteration per clock for four clocks, and presents the 8-bit product with a one-cycle `done` pulse. The ALU result mux selects `produto` for the multiply opcode.

## Interface
- Parameters: none. Operand width is 4 and product width is 8, both fixed by package constants.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: operation request, sampled on rising edge.
- `multiplicando` input 4: operand A, captured when `start` is accepted.
- `multiplicador` input 4: operand B, captured when `start` is accepted.
- `produto` output 8: registered product. Holds the last result until the next result is written.
- `busy` output 1: high while an operation is in progress (CALC state).
- `done` output 1: registered, high for exactly one cycle when `produto` is updated.

## Operation
- State machine: IDLE, CALC, DONE.
- **IDLE**
  - `start` = 1: load `A_reg` = `multiplicando`, `P` = {4'b0, `multiplicador`}, `cnt` = 0, go to CALC.
  - Otherwise stay in IDLE.
- **CALC**, one iteration per cycle:
  - If `P[0]`: compute {c, s} = `P[7:4]` + `A_reg` (5-bit sum) and set `P` = {c, s, `P[3:1]`}.
  - Else: `P` = {1'b0, `P[7:1]`}.
  - Increment `cnt`. On the iteration with `cnt` == 3, write the final `P` value into `produto` and go to DONE.
- **DONE**
  - `done` = 1.
  - `start` = 1: accepted exactly as in IDLE (back-to-back operation), go to CALC.
  - Otherwise go to IDLE.
- `start` during CALC is ignored. Operands are not re-captured and the in-flight operation is unaffected.
- Operand inputs are don't-care except in the cycle in which `start` is accepted.
- Arithmetic rules: the 5-bit add carry is never lost. The maximum unsigned product, 15×15 = 225, fits in 8 bits, so no overflow condition exists.
- `busy` = (state == CALC). `done` = (state == DONE). Both are decoded from the state register, so both are glitch-free registered outputs.

## Timing
- Reset (`rst` = 0, any time, including mid-CALC):
  - state = IDLE, `P` = 0, `A_reg` = 0, `cnt` = 0.
  - `produto` = 8'h00, `busy` = 0, `done` = 0.
  - Any in-flight operation is discarded.
- Latency, with `start` sampled at edge N:
  - `busy` = 1 after edge N.
  - Iterations occur at edges N+1..N+4.
  - `produto` is updated and `done` = 1 after edge N+4.
  - `done` falls at edge N+5, unless a new `start` re-enters CALC, in which case `done` still falls and `busy` rises.
- Throughput: one result every 5 cycles with `start` held high continuously.
- `produto` does not change during CALC. The previous result stays visible until the new result is written.

## Configuration
- Macro: `MULT_SIGNED_EN`.
- **Defined:** operands are two's-complement signed.
  - At `start`, the magnitudes |A| and |B| are loaded; |−8| = 4'b1000 is treated as unsigned 8.
  - `neg_reg` = `multiplicando[3]` XOR `multiplicador[3]` is captured.
  - On the final iteration, `produto` = `neg_reg` ? −P : P, in 8-bit two's complement.
  - Result range is −56..64. The latency is unchanged.
- **Undefined:** unsigned operation only. `neg_reg` and the negation logic are absent.

## Structure
- Shared package `ula_pkg`:
  - Constant `OP_W` = 4.
  - Constant `PROD_W` = 8.
  - Constant `MUL_ITER` = 4.
  - Typedef for the 2-bit state enum {IDLE, CALC, DONE}.
- Sub-module: the existing `somador_subtrator_4bits`, instantiated with `sub` = 0. It performs the `P[7:4]` + `A_reg` add, and its carry output supplies c.
- Everything else is inline in `multiplicador_4bits`.

## Test plan
- **Unsigned products:** 13 × 11 → `produto` = 8'h8F with `done` pulsed once, 5 cycles after `start`. Also 15 × 15 → 8'hE1, and 0 × 9 → 8'h00.
- **Ignored start:** `start` held high during CALC with different operands → the first result, 6 × 7 = 8'h2A, is unaffected. `busy` stays high for exactly 4 cycles.
- **Back-to-back:** `start` asserted in the DONE cycle → 3 × 5 = 8'h0F followed immediately by 9 × 9 = 8'h51. `done` pulses are separated by 5 cycles.
- **Reset mid-operation:** `rst` asserted low at iteration 2 of 12 × 12 → all outputs zero immediately, state IDLE. A subsequent 2 × 3 gives 8'h06.
- **Signed mode** (`MULT_SIGNED_EN` defined): −3 × 5 → 8'hF1. −8 × −8 → 8'h40. 7 × −8 → 8'hC8.
